song_sequencer: RTL and testbench
=================================

// Module: song_sequencer
// PURPOSE
//  Parametrised, table-driven successor to the fixed-case song players.
//  Plays one of NUM_SONGS tunes stored in an internal ROM of {end,dur,note} entries.
//  Outputs a note code each clock to the downstream tone generator / divider.
//  Adds tempo control, pause/resume, loop/one-shot mode, end-of-song pulse and position readback.
// PARAMETERS
//  NOTE_W      5      width of note code
//  DUR_W       4      duration field; note lasts (dur+1) beats
//  SONG_DEPTH  256    entries per song slot (power of 2)
//  NUM_SONGS   4      song slots; ROM depth = NUM_SONGS*SONG_DEPTH
//  TEMPO_W     16     width of tempo_div
//  REST_CODE   21     note code meaning silence
//  MEM_FILE    "songs.hex"  $readmemh image; entry = {end(1),dur(DUR_W),note(NOTE_W)}
// PORTS
//  clk         in   1        system clock, rising edge
//  rst         in   1        asynchronous, active-high reset
//  play        in   1        level; high = run, low = stop and return to IDLE
//  pause       in   1        level; high freezes playback
//  loop_en     in   1        sampled at start; 1 = restart at end of song
//  song_sel    in   clog2(NUM_SONGS)  song slot, sampled at start
//  tempo_div   in   TEMPO_W  clocks per beat; 0 treated as 1
//  note_out    out  NOTE_W   current note code
//  note_valid  out  1        note_out is a song note (not forced rest)
//  beat_strobe out  1        1-cycle pulse at each beat boundary
//  playing     out  1        high in FETCH/LATCH/PLAY
//  song_done   out  1        1-cycle pulse when one-shot song ends
//  pos         out  clog2(SONG_DEPTH)  index of entry being played
// BEHAVIOUR
//  Reset: state=IDLE, note_out=REST_CODE, note_valid=0, beat_strobe=0, playing=0, song_done=0, pos=0, counters=0.
//  States: IDLE, FETCH, LATCH, PLAY, PAUSE, DONE.
//  ROM: synchronous read; addr = sel_q*SONG_DEPTH + pos, presented in FETCH, data valid in LATCH.
//  IDLE: outputs rest. play=1 -> latch song_sel/loop_en, pos=0 -> FETCH.
//  FETCH -> LATCH unconditionally (1 cycle each).
//  LATCH, end=0: note_out=note, note_valid=1, beats_left=dur, tick_cnt=0 -> PLAY.
//  LATCH, end=1: if loop_q then pos=0 -> FETCH; else song_done=1 for 1 cycle, note_out=REST, note_valid=0 -> DONE.
//  PLAY: tick_cnt counts 0..max(tempo_div,1)-1. On wrap: beat_strobe=1.
//   If beats_left=0 -> pos+1 -> FETCH; else beats_left-1.
//  Note span = (dur+1)*T + 2 clocks, where T = max(tempo_div,1).
//   note_out holds the previous note during FETCH/LATCH.
//  pos at SONG_DEPTH-1 finishing: treated as end entry (loop or DONE); pos never indexes the next slot.
//  Pause:
//   pause=1 in PLAY -> PAUSE. Counters frozen; note_out=REST, note_valid=0.
//   pause=0 -> PLAY; resumes same note and tick_cnt.
//   pause in FETCH/LATCH takes effect on entry to PLAY.
//  play=0 in any state -> IDLE next edge. Outputs go to rest; pos=0; no song_done. play has priority over pause.
//  DONE: hold rest until play=0 -> IDLE. A new play rising edge restarts from entry 0.
//  song_sel/loop_en/tempo changes mid-song: sel/loop ignored until restart. tempo_div is used live at every wrap compare.
//  Latency: play sampled high at edge 0 -> note_valid=1 after edge 3.
//  Async rst mid-song: immediate return to reset values.
// TESTING
//  T1: song0={18,d1},{15,d0},{end}, T=4, loop=0 -> 18 for 10 clk, 15 for 6 clk, then REST; song_done 1 pulse; playing=0.
//  T2: same song, loop=1 -> sequence 18(10),15(4+2 end fetch+2 refetch) repeats; song_done never pulses.
//  T3: pause 3 clk into first beat of 18, hold 20 clk -> REST/note_valid=0 for 20 clk; then 18 resumes for remaining 7 clk.
//  T4: play low mid-note -> next edge IDLE, note_out=21, pos=0; play high -> restart at entry 0, note_valid after 3 edges.
//  T5: tempo_div=0, {9,d0} -> beat_strobe every clock; note 9 lasts 3 clk incl. fetch.
//  T6: song_sel=3 with no end flag in slot 3 -> plays all 256 entries, then stops at pos 255 (no spill); async rst mid-play clears all outputs immediately.

Source files
------------

// File: rtl/song_sequencer_if.sv
// Control/status bundle between a song_sequencer and its host.
// master = host side (drives play/pause/config), slave = sequencer side.
interface song_sequencer_if #(
  parameter int NOTE_W  = 5,
  parameter int TEMPO_W = 16,
  parameter int SEL_W   = 2,
  parameter int POS_W   = 8
);
  logic               play;
  logic               pause;
  logic               loop_en;
  logic [SEL_W-1:0]   song_sel;
  logic [TEMPO_W-1:0] tempo_div;
  logic [NOTE_W-1:0]  note_out;
  logic               note_valid;
  logic               beat_strobe;
  logic               playing;
  logic               song_done;
  logic [POS_W-1:0]   pos;

  modport master (
    output play, pause, loop_en, song_sel, tempo_div,
    input  note_out, note_valid, beat_strobe, playing, song_done, pos
  );

  modport slave (
    input  play, pause, loop_en, song_sel, tempo_div,
    output note_out, note_valid, beat_strobe, playing, song_done, pos
  );
endinterface

// File: rtl/song_sequencer.sv
// Table-driven song player: steps through {end,dur,note} ROM entries of the selected slot,
// emitting one note code per clock with tempo, pause, loop and end-of-song handling.
// States: IDLE rest/wait play | FETCH addr to ROM | LATCH ROM data in | PLAY count beats
//         PAUSE frozen, rest out | DONE one-shot finished, hold rest until play drops
module song_sequencer #(
  parameter int NOTE_W     = 5,
  parameter int DUR_W      = 4,
  parameter int SONG_DEPTH = 256,
  parameter int NUM_SONGS  = 4,
  parameter int TEMPO_W    = 16,
  parameter int REST_CODE  = 21,
  parameter logic [NUM_SONGS*SONG_DEPTH*(1+DUR_W+NOTE_W)-1:0] ROM_IMAGE = '0
) (
  input logic             clk,
  input logic             rst,
  song_sequencer_if.slave bus
);

  localparam int ENT_W = 1 + DUR_W + NOTE_W;
  localparam int POS_W = $clog2(SONG_DEPTH);
  localparam int SEL_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam logic [NOTE_W-1:0] REST     = NOTE_W'(REST_CODE);
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(SONG_DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]         state_q,  state_d;
  logic [SEL_W-1:0]   sel_q,    sel_d;
  logic               loop_q,   loop_d;
  logic [POS_W-1:0]   pos_q,    pos_d;
  logic [NOTE_W-1:0]  note_q,   note_d;
  logic               valid_q,  valid_d;
  logic [DUR_W-1:0]   beats_q,  beats_d;
  logic [TEMPO_W-1:0] tick_q,   tick_d;
  logic               strobe_q, strobe_d;
  logic               done_q,   done_d;
  logic [ENT_W-1:0]   rom_q;

  logic [SEL_W+POS_W-1:0] rom_addr;
  logic [TEMPO_W-1:0]     tdiv_m1;
  logic                   ent_end;
  logic [DUR_W-1:0]       ent_dur;
  logic [NOTE_W-1:0]      ent_note;
  logic                   end_hit;

  assign rom_addr = {sel_q, pos_q};
  assign ent_end  = rom_q[ENT_W-1];
  assign ent_dur  = rom_q[NOTE_W +: DUR_W];
  assign ent_note = rom_q[NOTE_W-1:0];
  // tempo_div of 0 behaves as 1; compared live so tempo changes apply at the next wrap
  assign tdiv_m1  = (bus.tempo_div == '0) ? '0 : bus.tempo_div - TEMPO_W'(1);

  always_ff @(posedge clk) begin
    rom_q <= ROM_IMAGE[int'(rom_addr)*ENT_W +: ENT_W];
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    loop_d   = loop_q;
    pos_d    = pos_q;
    note_d   = note_q;
    valid_d  = valid_q;
    beats_d  = beats_q;
    tick_d   = tick_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    end_hit  = 1'b0;
    if (!bus.play) begin
      state_d = S_IDLE;
      pos_d   = '0;
      note_d  = REST;
      valid_d = 1'b0;
      beats_d = '0;
      tick_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sel_d   = bus.song_sel;
          loop_d  = bus.loop_en;
          pos_d   = '0;
          state_d = S_FETCH;
        end
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          if (ent_end) begin
            end_hit = 1'b1;
          end else begin
            note_d  = ent_note;
            valid_d = 1'b1;
            beats_d = ent_dur;
            tick_d  = '0;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (bus.pause) begin
            state_d = S_PAUSE;
          end else if (tick_q >= tdiv_m1) begin
            tick_d   = '0;
            strobe_d = 1'b1;
            if (beats_q != '0) begin
              beats_d = beats_q - DUR_W'(1);
            end else if (pos_q == POS_LAST) begin
              end_hit = 1'b1;
            end else begin
              pos_d   = pos_q + POS_W'(1);
              state_d = S_FETCH;
            end
          end else begin
            tick_d = tick_q + TEMPO_W'(1);
          end
        end
        S_PAUSE: if (!bus.pause) state_d = S_PLAY;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
      // last slot entry finishing is handled exactly like an explicit end entry
      if (end_hit) begin
        if (loop_q) begin
          pos_d   = '0;
          state_d = S_FETCH;
        end else begin
          done_d  = 1'b1;
          note_d  = REST;
          valid_d = 1'b0;
          state_d = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      loop_q   <= 1'b0;
      pos_q    <= '0;
      note_q   <= REST;
      valid_q  <= 1'b0;
      beats_q  <= '0;
      tick_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      loop_q   <= loop_d;
      pos_q    <= pos_d;
      note_q   <= note_d;
      valid_q  <= valid_d;
      beats_q  <= beats_d;
      tick_q   <= tick_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign bus.note_out    = (state_q == S_PAUSE) ? REST : note_q;
  assign bus.note_valid  = valid_q & (state_q != S_PAUSE);
  assign bus.beat_strobe = strobe_q;
  assign bus.playing     = (state_q == S_FETCH) || (state_q == S_LATCH) || (state_q == S_PLAY);
  assign bus.song_done   = done_q;
  assign bus.pos         = pos_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: one-shot, loop, pause, stop/restart, tempo 0,
// full-slot playthrough without end flag, and async reset mid-song.
module tb_song_sequencer;

  localparam int IMG_W = 4 * 256 * 10;

  // slot0: 18 d1, 15 d0, end | slot1: 9 d0, end | slot2: 7 d3, end | slot3: note 11 everywhere, no end
  function automatic logic [IMG_W-1:0] build_rom();
    logic [IMG_W-1:0] img;
    img = {{256{10'h00B}}, {768{10'h001}}};
    img[0    +: 10] = {1'b0, 4'd1, 5'd18};
    img[10   +: 10] = {1'b0, 4'd0, 5'd15};
    img[20   +: 10] = 10'h200;
    img[2560 +: 10] = {1'b0, 4'd0, 5'd9};
    img[2570 +: 10] = 10'h200;
    img[5120 +: 10] = {1'b0, 4'd3, 5'd7};
    img[5130 +: 10] = 10'h200;
    return img;
  endfunction

  localparam logic [IMG_W-1:0] ROM_IMG = build_rom();

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulses;

  song_sequencer_if #(.NOTE_W(5), .TEMPO_W(16), .SEL_W(2), .POS_W(8)) bus_if ();

  song_sequencer #(
    .NOTE_W(5), .DUR_W(4), .SONG_DEPTH(256), .NUM_SONGS(4),
    .TEMPO_W(16), .REST_CODE(21), .ROM_IMAGE(ROM_IMG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int note_o();
    return int'(bus_if.note_out);
  endfunction

  initial begin
    rst               = 1'b1;
    bus_if.play       = 1'b0;
    bus_if.pause      = 1'b0;
    bus_if.loop_en    = 1'b0;
    bus_if.song_sel   = 2'd0;
    bus_if.tempo_div  = 16'd4;
    #12;
    chk("rst_note",    note_o(), 21);
    chk("rst_valid",   int'(bus_if.note_valid), 0);
    chk("rst_strobe",  int'(bus_if.beat_strobe), 0);
    chk("rst_playing", int'(bus_if.playing), 0);
    chk("rst_done",    int'(bus_if.song_done), 0);
    chk("rst_pos",     int'(bus_if.pos), 0);
    #10 rst = 1'b0;
    tick(1);

    // one-shot, T=4
    bus_if.play = 1'b1;
    tick(2);
    chk("t1_lat_valid",   int'(bus_if.note_valid), 0);
    chk("t1_lat_playing", int'(bus_if.playing), 1);
    tick(1);
    chk("t1_n18_first", note_o(), 18);
    chk("t1_valid",     int'(bus_if.note_valid), 1);
    tick(4);
    chk("t1_strobe_hi", int'(bus_if.beat_strobe), 1);
    tick(1);
    chk("t1_strobe_lo", int'(bus_if.beat_strobe), 0);
    tick(3);
    chk("t1_pos1",      int'(bus_if.pos), 1);
    chk("t1_n18_fetch", note_o(), 18);
    tick(1);
    chk("t1_n18_last",  note_o(), 18);
    tick(1);
    chk("t1_n15_first", note_o(), 15);
    tick(5);
    chk("t1_n15_last",  note_o(), 15);
    tick(1);
    chk("t1_end_note",    note_o(), 21);
    chk("t1_end_valid",   int'(bus_if.note_valid), 0);
    chk("t1_done_pulse",  int'(bus_if.song_done), 1);
    chk("t1_end_playing", int'(bus_if.playing), 0);
    chk("t1_end_pos",     int'(bus_if.pos), 2);
    tick(1);
    chk("t1_done_clear", int'(bus_if.song_done), 0);
    tick(5);
    chk("t1_done_hold_note", note_o(), 21);
    bus_if.play = 1'b0;
    tick(1);
    chk("t1_idle_pos", int'(bus_if.pos), 0);

    // loop mode; loop_en dropped mid-song must be ignored
    bus_if.loop_en = 1'b1;
    bus_if.play    = 1'b1;
    tick(1);
    bus_if.loop_en = 1'b0;
    tick(12);
    chk("t2_n15_first", note_o(), 15);
    tick(6);
    chk("t2_endfetch_note", note_o(), 15);
    chk("t2_loop_pos",      int'(bus_if.pos), 0);
    chk("t2_no_done",       int'(bus_if.song_done), 0);
    chk("t2_playing",       int'(bus_if.playing), 1);
    tick(1);
    chk("t2_refetch_note", note_o(), 15);
    tick(1);
    chk("t2_n18_again", note_o(), 18);
    tick(9);
    chk("t2_n18_hold", note_o(), 18);
    tick(1);
    chk("t2_n15_again", note_o(), 15);
    pulses = 0;
    repeat (40) begin
      tick(1);
      if (bus_if.song_done) pulses++;
    end
    chk("t2_done_pulses", pulses, 0);
    bus_if.play = 1'b0;
    tick(1);

    // pause after 3 counted ticks, held for 20 clocks
    bus_if.play = 1'b1;
    tick(6);
    chk("t3_pre_pause", note_o(), 18);
    bus_if.pause = 1'b1;
    tick(1);
    chk("t3_pause_note",    note_o(), 21);
    chk("t3_pause_valid",   int'(bus_if.note_valid), 0);
    chk("t3_pause_playing", int'(bus_if.playing), 0);
    tick(19);
    chk("t3_pause_end_note", note_o(), 21);
    bus_if.pause = 1'b0;
    tick(1);
    chk("t3_resume_note",  note_o(), 18);
    chk("t3_resume_valid", int'(bus_if.note_valid), 1);
    tick(1);
    chk("t3_resume_wrap", int'(bus_if.beat_strobe), 1);
    tick(5);
    chk("t3_n18_last", note_o(), 18);
    tick(1);
    chk("t3_n15", note_o(), 15);
    bus_if.play = 1'b0;
    tick(1);

    // stop mid-note, restart latency, play priority over pause
    bus_if.play = 1'b1;
    tick(14);
    chk("t4_mid_n15", note_o(), 15);
    chk("t4_mid_pos", int'(bus_if.pos), 1);
    bus_if.play = 1'b0;
    tick(1);
    chk("t4_stop_note",  note_o(), 21);
    chk("t4_stop_pos",   int'(bus_if.pos), 0);
    chk("t4_stop_valid", int'(bus_if.note_valid), 0);
    chk("t4_stop_done",  int'(bus_if.song_done), 0);
    bus_if.play = 1'b1;
    tick(2);
    chk("t4_restart_e2", int'(bus_if.note_valid), 0);
    tick(1);
    chk("t4_restart_e3_valid", int'(bus_if.note_valid), 1);
    chk("t4_restart_e3_note",  note_o(), 18);
    chk("t4_restart_e3_pos",   int'(bus_if.pos), 0);
    tick(2);
    bus_if.pause = 1'b1;
    bus_if.play  = 1'b0;
    tick(1);
    chk("t4_prio_playing", int'(bus_if.playing), 0);
    bus_if.pause = 1'b0;
    bus_if.play  = 1'b1;
    tick(1);
    chk("t4_prio_restart_e1", int'(bus_if.note_valid), 0);
    tick(2);
    chk("t4_prio_restart_e3", int'(bus_if.note_valid), 1);
    bus_if.play = 1'b0;
    tick(1);

    // tempo_div = 0 behaves as 1
    bus_if.song_sel  = 2'd1;
    bus_if.tempo_div = 16'd0;
    bus_if.play      = 1'b1;
    tick(3);
    chk("t5_n9_first", note_o(), 9);
    tick(1);
    chk("t5_strobe", int'(bus_if.beat_strobe), 1);
    chk("t5_n9_fetch", note_o(), 9);
    tick(1);
    chk("t5_n9_latch", note_o(), 9);
    chk("t5_strobe_lo", int'(bus_if.beat_strobe), 0);
    tick(1);
    chk("t5_end_note", note_o(), 21);
    chk("t5_done",     int'(bus_if.song_done), 1);
    bus_if.play = 1'b0;
    tick(1);

    bus_if.song_sel = 2'd2;
    bus_if.play     = 1'b1;
    tick(3);
    chk("t5b_n7", note_o(), 7);
    pulses = 0;
    repeat (5) begin
      tick(1);
      if (bus_if.beat_strobe) pulses++;
    end
    chk("t5b_strobes", pulses, 4);
    chk("t5b_n7_latch", note_o(), 7);
    tick(1);
    chk("t5b_end_note", note_o(), 21);
    chk("t5b_done",     int'(bus_if.song_done), 1);
    bus_if.play = 1'b0;
    tick(1);

    // slot 3 has no end flag: plays all 256 entries, stops at pos 255
    bus_if.song_sel = 2'd3;
    bus_if.play     = 1'b1;
    tick(1);
    bus_if.song_sel = 2'd0;
    tick(302);
    chk("t6_pos100",  int'(bus_if.pos), 100);
    chk("t6_note100", note_o(), 11);
    tick(465);
    chk("t6_pos255",   int'(bus_if.pos), 255);
    chk("t6_note255",  note_o(), 11);
    chk("t6_valid255", int'(bus_if.note_valid), 1);
    tick(1);
    chk("t6_done",      int'(bus_if.song_done), 1);
    chk("t6_stop_pos",  int'(bus_if.pos), 255);
    chk("t6_stop_note", note_o(), 21);
    chk("t6_playing",   int'(bus_if.playing), 0);
    bus_if.play = 1'b0;
    tick(1);

    // async reset mid-song
    bus_if.song_sel = 2'd3;
    bus_if.play     = 1'b1;
    tick(21);
    chk("t6_pre_rst_pos",   int'(bus_if.pos), 6);
    chk("t6_pre_rst_valid", int'(bus_if.note_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_note",    note_o(), 21);
    chk("t6_arst_valid",   int'(bus_if.note_valid), 0);
    chk("t6_arst_pos",     int'(bus_if.pos), 0);
    chk("t6_arst_playing", int'(bus_if.playing), 0);
    bus_if.play = 1'b0;
    #5 rst = 1'b0;
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
